change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser_pkg.sv | 37 +++
 rtl/change_dispenser_if.sv | 36 +++
 rtl/change_dispenser_coin_select.sv | 32 +++
 rtl/change_dispenser.sv | 133 +++++++++++++
 tb/tb_change_dispenser.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: coin values, coin index
// encoding, FSM state encoding, stock and amount widths.
package change_dispenser_pkg;

  localparam int STOCK_W   = 8;
  localparam int AMT_W     = 9;
  localparam int NUM_COINS = 4;

  // Index of each coin inside the stock array and the one-hot coin vector.
  typedef enum logic [1:0] {
    COIN_NICKEL  = 2'd0,
    COIN_DIME    = 2'd1,
    COIN_QUARTER = 2'd2,
    COIN_DOLLAR  = 2'd3
  } coin_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    PULSE  = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } state_e;

  typedef logic [NUM_COINS-1:0][STOCK_W-1:0] stockArr_t;

  // Face value in cents of the coin at a given index.
  function automatic logic [AMT_W-1:0] coinValue(input logic [1:0] idx);
    case (idx)
      COIN_NICKEL:  coinValue = 9'd5;
      COIN_DIME:    coinValue = 9'd10;
      COIN_QUARTER: coinValue = 9'd25;
      default:      coinValue = 9'd100;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Bus between the vending controller (master) and the change dispenser
// (slave).
//   changeReq/change     : level request and amount in cents
//   stockLoad/stockIn    : one-cycle stock reload {dollar,quarter,dime,nickel}
//   *Out                 : one-cycle coin eject pulses
//   changeDone/shortfall : completion flag and cents not returned
//   busy/emptyFlags      : status
interface change_dispenser_if;
  import change_dispenser_pkg::*;

  logic             changeReq;
  logic [AMT_W-1:0] change;
  logic             stockLoad;
  logic [31:0]      stockIn;
  logic             dollarOut;
  logic             quarterOut;
  logic             dimeOut;
  logic             nickelOut;
  logic             changeDone;
  logic [AMT_W-1:0] shortfall;
  logic             busy;
  logic [3:0]       emptyFlags;

  modport master (
    output changeReq, change, stockLoad, stockIn,
    input  dollarOut, quarterOut, dimeOut, nickelOut,
           changeDone, shortfall, busy, emptyFlags
  );

  modport slave (
    input  changeReq, change, stockLoad, stockIn,
    output dollarOut, quarterOut, dimeOut, nickelOut,
           changeDone, shortfall, busy, emptyFlags
  );

endinterface

// File: rtl/change_dispenser_coin_select.sv
// Combinational coin chooser: picks the largest coin whose value fits in the
// remaining amount and which is still in stock.
//   remaining : cents still owed
//   stock     : per-coin counts
//   pick      : one-hot coin choice (all zero when nothing fits)
//   pickValue : value of the chosen coin (zero when nothing fits)
module coin_select
  import change_dispenser_pkg::*;
(
  input  logic [AMT_W-1:0]     remaining,
  input  stockArr_t            stock,
  output logic [NUM_COINS-1:0] pick,
  output logic [AMT_W-1:0]     pickValue
);

  logic found;

  // Scan from the dollar down so the first fit is the largest coin.
  always_comb begin
    pick      = '0;
    pickValue = '0;
    found     = 1'b0;
    for (int i = NUM_COINS - 1; i >= 0; i--) begin
      if (!found && (stock[i] != '0) && (coinValue(2'(i)) <= remaining)) begin
        pick[i]   = 1'b1;
        pickValue = coinValue(2'(i));
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: on request, ejects the largest available coins one at a
// time, separated by GAP_CYCLES idle cycles, then reports any amount it could
// not return. All outputs come straight from registers.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : change_dispenser_if slave (request, stock reload, coin
//              pulses, completion handshake, status)
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int DEFAULT_STOCK = 8,
  parameter int GAP_CYCLES    = 1
) (
  input logic               clk,
  input logic               rst,
  change_dispenser_if.slave bus
);

  state_e                 state, stateNext;
  logic [AMT_W-1:0]       remaining, remainingNext;
  stockArr_t              stock, stockNext;
  logic [NUM_COINS-1:0]   coinOut, coinOutNext;
  logic [AMT_W-1:0]       selVal, selValNext;
  logic [2:0]             gapCnt, gapCntNext;
  logic                   doneReg, doneNext;
  logic [AMT_W-1:0]       shortfallReg, shortfallNext;
  logic                   busyReg, busyNext;
  logic [NUM_COINS-1:0]   emptyReg, emptyNext;
  logic [NUM_COINS-1:0]   pick;
  logic [AMT_W-1:0]       pickValue;

  coin_select uSelect (
    .remaining (remaining),
    .stock     (stock),
    .pick      (pick),
    .pickValue (pickValue)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      remaining    <= '0;
      stock        <= {NUM_COINS{STOCK_W'(DEFAULT_STOCK)}};
      coinOut      <= '0;
      selVal       <= '0;
      gapCnt       <= '0;
      doneReg      <= 1'b0;
      shortfallReg <= '0;
      busyReg      <= 1'b0;
      emptyReg     <= (DEFAULT_STOCK == 0) ? '1 : '0;
    end else begin
      state        <= stateNext;
      remaining    <= remainingNext;
      stock        <= stockNext;
      coinOut      <= coinOutNext;
      selVal       <= selValNext;
      gapCnt       <= gapCntNext;
      doneReg      <= doneNext;
      shortfallReg <= shortfallNext;
      busyReg      <= busyNext;
      emptyReg     <= emptyNext;
    end
  end

  always_comb begin
    stateNext     = state;
    remainingNext = remaining;
    stockNext     = stock;
    coinOutNext   = '0;
    selValNext    = selVal;
    gapCntNext    = gapCnt;
    doneNext      = doneReg;
    shortfallNext = shortfallReg;
    case (state)
      IDLE: begin
        // A reload takes priority; a request held alongside it is taken
        // on the following cycle.
        if (bus.stockLoad) begin
          stockNext = bus.stockIn;
        end else if (bus.changeReq) begin
          remainingNext = bus.change;
          stateNext     = SELECT;
        end
      end
      SELECT: begin
        if (pick != '0) begin
          coinOutNext = pick;
          selValNext  = pickValue;
          stateNext   = PULSE;
        end else begin
          doneNext      = 1'b1;
          shortfallNext = remaining;
          stateNext     = DONE;
        end
      end
      PULSE: begin
        // coin_select only chose this coin if it fit and was in stock,
        // so neither subtraction can wrap.
        remainingNext = remaining - selVal;
        for (int i = 0; i < NUM_COINS; i++) begin
          if (coinOut[i]) stockNext[i] = stock[i] - 8'd1;
        end
        gapCntNext = 3'(GAP_CYCLES - 1);
        stateNext  = GAP;
      end
      GAP: begin
        if (gapCnt == '0) stateNext = SELECT;
        else              gapCntNext = gapCnt - 3'd1;
      end
      DONE: begin
        if (!bus.changeReq) begin
          doneNext      = 1'b0;
          shortfallNext = '0;
          stateNext     = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    busyNext = (stateNext != IDLE);
    for (int i = 0; i < NUM_COINS; i++) begin
      emptyNext[i] = (stockNext[i] == '0);
    end
  end

  assign bus.dollarOut  = coinOut[COIN_DOLLAR];
  assign bus.quarterOut = coinOut[COIN_QUARTER];
  assign bus.dimeOut    = coinOut[COIN_DIME];
  assign bus.nickelOut  = coinOut[COIN_NICKEL];
  assign bus.changeDone = doneReg;
  assign bus.shortfall  = shortfallReg;
  assign bus.busy       = busyReg;
  assign bus.emptyFlags = emptyReg;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus pushes the expected coin
// sequence and final shortfall; a negedge monitor pops and compares them.
module tb_change_dispenser;
  import change_dispenser_pkg::*;

  localparam int GAP = 1;
  localparam logic [3:0] D = 4'b1000, Q = 4'b0100, M = 4'b0010, N = 4'b0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  change_dispenser_if dif();

  change_dispenser #(.DEFAULT_STOCK(8), .GAP_CYCLES(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  typedef struct {
    bit         isDone;
    logic [3:0] coins;
    int         shortfall;
  } ev_t;

  ev_t sbQ[$];
  int  compared   = 0;
  int  mismatched = 0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] coinBits();
    return {dif.dollarOut, dif.quarterOut, dif.dimeOut, dif.nickelOut};
  endfunction

  task automatic pushCoin(input logic [3:0] c);
    ev_t e;
    e.isDone = 1'b0; e.coins = c; e.shortfall = 0;
    sbQ.push_back(e);
  endtask

  task automatic pushDone(input int sf);
    ev_t e;
    e.isDone = 1'b1; e.coins = 4'b0; e.shortfall = sf;
    sbQ.push_back(e);
  endtask

  // Monitor: compares every coin pulse and every changeDone rise against
  // the scoreboard, and checks the pulse-shape rules.
  logic [3:0] prevCoins = '0;
  logic       prevDone  = 1'b0;
  bit         havePrev  = 1'b0;
  int         cyc       = 0;
  int         lastPulse = 0;

  always @(negedge clk) begin
    logic [3:0] c;
    ev_t e;
    c = coinBits();
    cyc++;
    if (rst) begin
      prevCoins = '0; prevDone = 1'b0; havePrev = 1'b0;
    end else begin
      if (c != '0) begin
        check("one_coin_per_cycle", $countones(c), 1);
        check("no_back_to_back", int'(c & prevCoins), 0);
        if (havePrev) check("pulse_spacing", cyc - lastPulse, GAP + 2);
        havePrev = 1'b1; lastPulse = cyc;
        if (sbQ.size() == 0) check("unexpected_coin", int'(c), 0);
        else begin
          e = sbQ.pop_front();
          check("coin_kind", int'(c), e.isDone ? 0 : int'(e.coins));
        end
      end
      if (dif.changeDone && !prevDone) begin
        havePrev = 1'b0;
        if (sbQ.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = sbQ.pop_front();
          check("done_in_order", int'(e.isDone), 1);
          check("shortfall", int'(dif.shortfall), e.shortfall);
        end
      end
      prevCoins = c;
      prevDone  = dif.changeDone;
    end
  end

  task automatic loadStock(input logic [31:0] v);
    @(negedge clk);
    dif.stockLoad = 1'b1; dif.stockIn = v;
    @(negedge clk);
    dif.stockLoad = 1'b0;
  endtask

  // mode 0: plain request; 1: stockLoad together with the request;
  // 2: stockLoad during the first pulse; 3: drop changeReq at first pulse.
  task automatic runReq(input int amount, input int expLat, input int hold,
                        input int mode, input logic [31:0] loadVal);
    int n;
    bit seen;
    @(negedge clk);
    dif.change = 9'(amount);
    dif.changeReq = 1'b1;
    if (mode == 1) begin dif.stockLoad = 1'b1; dif.stockIn = loadVal; end
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk); n++;
      dif.stockLoad = 1'b0;
      if (coinBits() != '0 || dif.changeDone) seen = 1'b1;
    end
    check("first_event_latency", n, expLat);
    if (mode == 2) begin dif.stockLoad = 1'b1; dif.stockIn = loadVal; end
    if (mode == 3) dif.changeReq = 1'b0;
    n = 0;
    while (!dif.changeDone && n < 200) begin
      @(negedge clk); n++;
      dif.stockLoad = 1'b0;
    end
    check("done_raised", int'(dif.changeDone), 1);
    repeat (hold) begin
      @(negedge clk);
      check("done_held", int'(dif.changeDone), 1);
    end
    dif.changeReq = 1'b0;
    @(negedge clk);
    check("done_dropped", int'(dif.changeDone), 0);
    check("busy_idle", int'(dif.busy), 0);
    check("shortfall_cleared", int'(dif.shortfall), 0);
    check("scoreboard_drained", sbQ.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    dif.changeReq = 1'b0; dif.change = '0;
    dif.stockLoad = 1'b0; dif.stockIn = '0;
    repeat (2) @(negedge clk);
    // Reset state
    check("rst_coins", int'(coinBits()), 0);
    check("rst_done", int'(dif.changeDone), 0);
    check("rst_shortfall", int'(dif.shortfall), 0);
    check("rst_busy", int'(dif.busy), 0);
    check("rst_empty", int'(dif.emptyFlags), 0);
    check("rst_stock", int'(dut.stock[0]), 8);
    rst = 1'b0;

    // 140 with full stock: dollar, quarter, dime, nickel
    pushCoin(D); pushCoin(Q); pushCoin(M); pushCoin(N); pushDone(0);
    runReq(140, 2, 0, 0, 32'h0);

    // No quarters, 30 -> three dimes
    loadStock(32'h08000808);
    pushCoin(M); pushCoin(M); pushCoin(M); pushDone(0);
    runReq(30, 2, 0, 0, 32'h0);
    check("dime_stock_after_30", int'(dut.stock[1]), 5);
    check("empty_quarter", int'(dif.emptyFlags), 4'b0100);

    // Zero amount: done after two cycles, held while request stays high
    pushDone(0);
    runReq(0, 2, 4, 0, 32'h0);

    // One nickel only, 17 -> nickel, shortfall 12, all empty
    loadStock(32'h00000001);
    pushCoin(N); pushDone(12);
    runReq(17, 2, 0, 0, 32'h0);
    check("all_empty", int'(dif.emptyFlags), 4'b1111);

    // Non-multiple of 5 with full stock
    loadStock(32'h08080808);
    pushCoin(N); pushDone(2);
    runReq(7, 2, 0, 0, 32'h0);

    // Reset during the gap after the dollar pulse
    loadStock(32'h08080808);
    pushCoin(D);
    @(negedge clk);
    dif.change = 9'd140; dif.changeReq = 1'b1;
    n = 0;
    while (!dif.dollarOut && n < 20) begin @(negedge clk); n++; end
    check("dollar_before_abort", int'(dif.dollarOut), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_coins", int'(coinBits()), 0);
    check("abort_busy", int'(dif.busy), 0);
    check("abort_done", int'(dif.changeDone), 0);
    @(negedge clk);
    rst = 1'b0; dif.changeReq = 1'b0;
    check("abort_dollar_stock", int'(dut.stock[3]), 8);
    repeat (8) @(negedge clk);
    check("abort_no_more_events", sbQ.size(), 0);
    pushCoin(D); pushCoin(Q); pushCoin(M); pushCoin(N); pushDone(0);
    runReq(140, 2, 0, 0, 32'h0);

    // stockLoad during PULSE is ignored
    loadStock(32'h08080808);
    pushCoin(Q); pushDone(0);
    runReq(25, 2, 0, 2, 32'h0);
    check("quarter_stock_after_ignored_load", int'(dut.stock[2]), 7);
    check("dollar_stock_after_ignored_load", int'(dut.stock[3]), 8);
    check("no_empty_after_ignored_load", int'(dif.emptyFlags), 0);

    // Load and request together: load first, request one cycle later
    pushCoin(M); pushCoin(M); pushDone(0);
    runReq(20, 3, 0, 1, 32'h00000200);
    check("empty_after_two_dimes", int'(dif.emptyFlags), 4'b1111);

    // Request dropped before completion: dispense finishes, one-cycle done
    loadStock(32'h08080808);
    pushCoin(M); pushCoin(N); pushDone(0);
    runReq(15, 2, 0, 3, 32'h0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
